ham_encoder_stream: RTL

Streaming Hamming(7,4) encoder that sits directly upstream of the team's `ham_decoder`. It accepts 4-bit data nibbles over a valid/ready handshake, buffers them in a small FIFO, and encodes each one into a 7-bit codeword. Each codeword is presented on a registered valid/ready output whose `enc_ham_data` bus feeds the decoder's input of the same name. An optional error-injection stage corrupts one chosen codeword bit so the decoder's correction path can be exercised end to end.

---
 rtl/ham_encoder_stream.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ham_encoder_stream.sv
// Streaming Hamming(7,4) encoder: input FIFO, registered codeword output and an
// optional single-bit error-injection stage built when HAM_ERR_INJ_EN is defined.
module ham_encoder_stream #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               enc_ham_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              word_cnt,
    input  logic                     err_inj_arm,
    input  logic [2:0]               err_inj_pos,
    output logic                     err_inj_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic parity3(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Codeword bit [p-1] is Hamming position p; data sits at the non-power-of-two slots.
    function automatic logic [6:0] ham_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = parity3(d[0], d[1], d[3]);
        p2 = parity3(d[0], d[2], d[3]);
        p4 = parity3(d[1], d[2], d[3]);
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    logic [3:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [6:0]    enc_r;
    logic [15:0]   word_cnt_r;
    logic          push_s;
    logic          load_s;
    logic          handshake_s;
    logic [6:0]    code_s;
    logic [6:0]    flip_s;
    logic          inj_busy_s;

    assign push_s      = in_valid && in_ready_r;
    assign load_s      = (count_r != {CW{1'b0}}) && (!out_valid_r || out_ready);
    assign handshake_s = out_valid_r && out_ready;

    // Next FIFO occupancy from this cycle's push/pop pair.
    always_comb begin
        count_next_s = count_r;
        if (push_s && !load_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_s && load_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s < DEPTH_C);
        end
    end

`ifdef HAM_ERR_INJ_EN
    typedef enum logic {
        INJ_IDLE  = 1'b0,
        INJ_ARMED = 1'b1
    } inj_state_t;

    inj_state_t inj_state_r;
    logic [2:0] inj_pos_r;

    // Injection FSM: an arm seen in IDLE only affects the load after this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_state_r <= INJ_IDLE;
            inj_pos_r   <= 3'd0;
        end else begin
            case (inj_state_r)
                INJ_IDLE: begin
                    if (err_inj_arm) begin
                        inj_state_r <= INJ_ARMED;
                        inj_pos_r   <= err_inj_pos;
                    end
                end
                INJ_ARMED: begin
                    if (load_s) begin
                        inj_state_r <= INJ_IDLE;
                    end
                end
                default: begin
                    inj_state_r <= INJ_IDLE;
                end
            endcase
        end
    end

    // Flip mask for the pending injection; position 0 means a clean word.
    always_comb begin
        flip_s = 7'd0;
        if ((inj_state_r == INJ_ARMED) && (inj_pos_r != 3'd0)) begin
            flip_s = 7'd1 << (inj_pos_r - 3'd1);
        end else begin
            flip_s = 7'd0;
        end
    end

    assign inj_busy_s = (inj_state_r == INJ_ARMED);
`else
    logic unused_inj_s;

    assign unused_inj_s = ^{err_inj_arm, err_inj_pos};
    assign flip_s       = 7'd0;
    assign inj_busy_s   = 1'b0;
`endif

    assign code_s = ham_encode(mem_r[rd_ptr_r]) ^ flip_s;

    // Output register: held while stalled, cleared after a handshake with no refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            enc_r       <= 7'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            enc_r       <= code_s;
        end else if (handshake_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Completed-handshake counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_r <= 16'd0;
        end else if (handshake_s) begin
            word_cnt_r <= word_cnt_r + 16'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign enc_ham_data = enc_r;
    assign fifo_count   = count_r;
    assign word_cnt     = word_cnt_r;
    assign err_inj_busy = inj_busy_s;

endmodule
